bfp16_round_pack: RTL and testbench
===================================

Name: bfp16_round_pack

Overview:
- Streaming FP32 to BFP16 converter with round-to-nearest-even. It is the producer that feeds the BFP16 adder datapath.
- Output is BFP16 in the 32-bit container: sign, 8-bit exponent and 7-bit mantissa in bits [31:16], bits [15:0] forced to zero.
- Canonicalises special values into the forms the adder expects: zero is exactly 32'h0, NaN is quiet.
- 2-stage elastic valid/ready pipeline, full throughput, with saturating event counters for debug.

Parameters:
- SIZE_DATA, 32, container width; fixed at 32, other values unsupported.
- SIZE_CNT, 16, width of each event counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  SIZE_DATA  FP32 input word.
- i_valid  in  1  input word valid.
- o_ready  out  1  block can accept a word this cycle.
- o_data  out  SIZE_DATA  BFP16 result, bits [15:0] always 0.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data this cycle.
- i_clr_cnt  in  1  synchronous clear of all counters.
- o_cnt_round_up  out  SIZE_CNT  number of accepted words where rounding incremented the mantissa.
- o_cnt_overflow  out  SIZE_CNT  number of finite inputs that rounded to infinity.
- o_cnt_flush  out  SIZE_CNT  number of zero or denormal inputs flushed to 32'h0.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - Both stage valid flags, stage data registers, o_data and all counters go to 0.
  - o_valid=0; o_ready=1 once reset is released.
  - Reset mid-stream drops all in-flight words.
- Handshake:
  - Input transfer when i_valid && o_ready. Output transfer when o_valid && i_ready.
  - o_valid and o_data stay stable while o_valid && !i_ready.
- Pipeline:
  - S1 advances into S2 when S2 is empty or S2 is transferring out.
  - o_ready = !s1_valid || s1 advances. The combinational path from i_ready to o_ready is allowed.
  - Latency: 2 cycles from input transfer to o_valid when there is no stall. One word per cycle sustained.
  - With i_ready=0, two words are held and o_ready drops to 0. No loss, no reordering.
- S1 work: classify the input and round, registering the result and counter events.
  - Let e = i_data[30:23] and m = i_data[22:0].
  - NaN (e=8'hFF, m!=0): output {sign, 8'hFF, 7'h40, 16'h0}. Not counted.
  - Inf (e=8'hFF, m=0): output {sign, 8'hFF, 23'h0}. Not counted.
  - Zero or denormal (e=0): output 32'h0 (sign dropped). cnt_flush increments.
  - Normal:
    - lsb = i_data[16], guard = i_data[15], sticky = |i_data[14:0].
    - inc = guard && (sticky || lsb).
    - r = i_data[30:16] + inc, computed as a 15-bit add. Mantissa carry propagates into the exponent.
    - Output {sign, r, 16'h0}.
    - inc=1 increments cnt_round_up.
    - If r[14:7] = 8'hFF, the result equals Inf (mantissa is 0 by construction) and cnt_overflow also increments.
- Counters:
  - Update only on input transfer.
  - Saturate at all-ones; no wrap.
  - i_clr_cnt takes priority over a simultaneous increment: the counter goes to 0 and the event is not counted.
- S2: pure register stage holding o_data and o_valid.

Test Plan:
- Ties to even: 32'h3F808000 -> 32'h3F800000 with cnt_round_up=0. 32'h3F818000 -> 32'h3F820000 with cnt_round_up=1.
- Sticky and mantissa carry: 32'h3F808001 -> 32'h3F810000. 32'h3FFF8000 -> 32'h40000000 (exponent increments).
- Overflow: 32'h7F7FFFFF -> 32'h7F800000 with cnt_overflow=1 and cnt_round_up=1. 32'hFF7FFFFF -> 32'hFF800000.
- Specials:
  - 32'h7F800001 -> 32'h7FC00000.
  - 32'hFFC12345 -> 32'hFFC00000.
  - 32'h7F800000 passes unchanged.
  - 32'h80000000 -> 32'h0 and 32'h00400000 -> 32'h0, giving cnt_flush=2.
- Backpressure: stream 6 words back-to-back and hold i_ready=0 for 3 cycles mid-stream.
  - o_ready falls to 0 with 2 words held.
  - All 6 outputs arrive in order, unchanged.
  - Output is 1 word/cycle after i_ready returns to 1.
- Reset and clear:
  - Assert i_rst_n=0 with 2 words in flight: o_valid=0 immediately, no stale word after release.
  - i_clr_cnt=1 in the same cycle as a rounding input: cnt_round_up reads 0 next cycle.
  - With SIZE_CNT=2, 5 round-up inputs leave cnt_round_up at 3.

Source files
------------

// File: rtl/bfp16_round_pack_if.sv
// Stream and debug-counter bundle for the FP32 -> BFP16 round/pack stage.
// Signal names are taken from the block's point of view: i_* flow in, o_* flow out.
interface bfp16_round_pack_if #(
   parameter int SIZE_DATA = 32,
   parameter int SIZE_CNT  = 16
);
   logic [SIZE_DATA-1:0] i_data;
   logic                 i_valid;
   logic                 o_ready;
   logic [SIZE_DATA-1:0] o_data;
   logic                 o_valid;
   logic                 i_ready;
   logic                 i_clr_cnt;
   logic [SIZE_CNT-1:0]  o_cnt_round_up;
   logic [SIZE_CNT-1:0]  o_cnt_overflow;
   logic [SIZE_CNT-1:0]  o_cnt_flush;

   modport master (
      output i_data, i_valid, i_ready, i_clr_cnt,
      input  o_ready, o_data, o_valid, o_cnt_round_up, o_cnt_overflow, o_cnt_flush
   );

   modport slave (
      input  i_data, i_valid, i_ready, i_clr_cnt,
      output o_ready, o_data, o_valid, o_cnt_round_up, o_cnt_overflow, o_cnt_flush
   );
endinterface

// File: rtl/bfp16_round_pack.sv
// Streaming FP32 -> BFP16 converter (round-to-nearest-even) with canonical specials,
// a 2-stage elastic valid/ready pipeline and saturating debug event counters.
module bfp16_round_pack #(
   parameter int SIZE_DATA = 32,
   parameter int SIZE_CNT  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   bfp16_round_pack_if.slave bus
);
   localparam int N_CNT       = 3;
   localparam int EV_ROUND_UP = 0;
   localparam int EV_OVERFLOW = 1;
   localparam int EV_FLUSH    = 2;
   localparam logic [SIZE_CNT-1:0] CNT_ONE = {{(SIZE_CNT-1){1'b0}}, 1'b1};

   logic                 s1_valid_q, s1_valid_d;
   logic [SIZE_DATA-1:0] s1_data_q, s1_data_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [SIZE_DATA-1:0] s2_data_q, s2_data_d;

   logic                 s1_adv;
   logic                 ready;
   logic                 in_xfer;
   logic                 out_xfer;

   logic                 sign;
   logic [7:0]           exp_in;
   logic [22:0]          man_in;
   logic                 lsb;
   logic                 guard;
   logic                 sticky;
   logic                 inc;
   logic [14:0]          rnd;
   logic [SIZE_DATA-1:0] conv_data;
   logic [N_CNT-1:0]     conv_ev;
   logic [SIZE_CNT-1:0]  cnt_val [N_CNT];

   // Classification and rounding of the word currently presented at the input.
   always_comb begin
      sign      = bus.i_data[31];
      exp_in    = bus.i_data[30:23];
      man_in    = bus.i_data[22:0];
      lsb       = bus.i_data[16];
      guard     = bus.i_data[15];
      sticky    = |bus.i_data[14:0];
      inc       = guard && (sticky || lsb);
      // Exponent and kept mantissa as one field so a mantissa carry bumps the exponent.
      rnd       = bus.i_data[30:16] + {14'd0, inc};
      conv_data = '0;
      conv_ev   = '0;
      if (exp_in == 8'hFF) begin
         if (man_in != 23'd0) begin
            conv_data = {sign, 8'hFF, 7'h40, 16'h0000};
         end else begin
            conv_data = {sign, 8'hFF, 23'd0};
         end
      end else if (exp_in == 8'h00) begin
         conv_data          = '0;
         conv_ev[EV_FLUSH]  = 1'b1;
      end else begin
         conv_data            = {sign, rnd, 16'h0000};
         conv_ev[EV_ROUND_UP] = inc;
         conv_ev[EV_OVERFLOW] = (rnd[14:7] == 8'hFF);
      end
   end

   assign s1_adv      = s1_valid_q && (!s2_valid_q || bus.i_ready);
   assign ready       = !s1_valid_q || s1_adv;
   assign in_xfer     = bus.i_valid && ready;
   assign out_xfer    = s2_valid_q && bus.i_ready;

   assign bus.o_ready = ready;
   assign bus.o_valid = s2_valid_q;
   assign bus.o_data  = s2_data_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_data_d  = conv_data;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_data_d  = s1_data_q;
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   // One saturating counter per event; clear wins over a same-cycle event.
   for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      logic [SIZE_CNT-1:0] cnt_q;
      logic [SIZE_CNT-1:0] cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (bus.i_clr_cnt) begin
            cnt_d = '0;
         end else if (in_xfer && conv_ev[gi] && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_val[gi] = cnt_q;
   end

   assign bus.o_cnt_round_up = cnt_val[EV_ROUND_UP];
   assign bus.o_cnt_overflow = cnt_val[EV_OVERFLOW];
   assign bus.o_cnt_flush    = cnt_val[EV_FLUSH];

endmodule

// File: tb/tb_bfp16_round_pack.sv
// Directed bench for bfp16_round_pack: vector table, backpressure, reset, clear, saturation.
module tb_bfp16_round_pack;
   logic clk;
   logic rst_n;

   bfp16_round_pack_if #(.SIZE_DATA(32), .SIZE_CNT(16)) bus ();
   bfp16_round_pack_if #(.SIZE_DATA(32), .SIZE_CNT(2))  bus2 ();

   bfp16_round_pack #(.SIZE_DATA(32), .SIZE_CNT(16)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   bfp16_round_pack #(.SIZE_DATA(32), .SIZE_CNT(2)) u_dut_sat (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
      int          ru;
      int          ov;
      int          fl;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   // Push one word into the main DUT with i_ready=1 and capture the result.
   task automatic send_one(input logic [31:0] din, output logic [31:0] dout, output bit seen);
      seen = 1'b0;
      dout = '0;
      @(negedge clk);
      bus.i_data  = din;
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         #1;
         if (bus.o_valid) begin
            seen = 1'b1;
            dout = bus.o_data;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [13];
      logic [31:0] bp_in  [6];
      logic [31:0] bp_exp [6];
      int          out_cyc [6];
      logic [31:0] got;
      bit          seen;
      int          ru_exp, ov_exp, fl_exp;
      int          sent, rcvd, seen_cnt;

      vecs[0]  = '{32'h3F808000, 32'h3F800000, 0, 0, 0};
      vecs[1]  = '{32'h3F818000, 32'h3F820000, 1, 0, 0};
      vecs[2]  = '{32'h3F808001, 32'h3F810000, 1, 0, 0};
      vecs[3]  = '{32'h3FFF8000, 32'h40000000, 1, 0, 0};
      vecs[4]  = '{32'h7F7FFFFF, 32'h7F800000, 1, 1, 0};
      vecs[5]  = '{32'hFF7FFFFF, 32'hFF800000, 1, 1, 0};
      vecs[6]  = '{32'h7F800001, 32'h7FC00000, 0, 0, 0};
      vecs[7]  = '{32'hFFC12345, 32'hFFC00000, 0, 0, 0};
      vecs[8]  = '{32'h7F800000, 32'h7F800000, 0, 0, 0};
      vecs[9]  = '{32'h80000000, 32'h00000000, 0, 0, 1};
      vecs[10] = '{32'h00400000, 32'h00000000, 0, 0, 1};
      vecs[11] = '{32'h3F807FFF, 32'h3F800000, 0, 0, 0};
      vecs[12] = '{32'hBF80FFFF, 32'hBF810000, 1, 0, 0};

      bp_in[0] = 32'h3F818000; bp_exp[0] = 32'h3F820000;
      bp_in[1] = 32'h40490FDB; bp_exp[1] = 32'h40490000;
      bp_in[2] = 32'hC0000000; bp_exp[2] = 32'hC0000000;
      bp_in[3] = 32'h3FFF8000; bp_exp[3] = 32'h40000000;
      bp_in[4] = 32'h7F800001; bp_exp[4] = 32'h7FC00000;
      bp_in[5] = 32'h41200000; bp_exp[5] = 32'h41200000;

      bus.i_data = '0;  bus.i_valid = 1'b0;  bus.i_ready = 1'b1;  bus.i_clr_cnt = 1'b0;
      bus2.i_data = '0; bus2.i_valid = 1'b0; bus2.i_ready = 1'b1; bus2.i_clr_cnt = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_o_data", bus.o_data, 32'd0);
      chk("rst_cnt_round_up", {16'd0, bus.o_cnt_round_up}, 32'd0);
      chk("rst_cnt_overflow", {16'd0, bus.o_cnt_overflow}, 32'd0);
      chk("rst_cnt_flush", {16'd0, bus.o_cnt_flush}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_o_ready", {31'd0, bus.o_ready}, 32'd1);

      // Vector table
      ru_exp = 0; ov_exp = 0; fl_exp = 0;
      for (int i = 0; i < 13; i++) begin
         send_one(vecs[i].din, got, seen);
         ru_exp += vecs[i].ru;
         ov_exp += vecs[i].ov;
         fl_exp += vecs[i].fl;
         chk($sformatf("vec%0d_seen", i), {31'd0, seen}, 32'd1);
         chk($sformatf("vec%0d_data in=%h", i, vecs[i].din), got, vecs[i].dout);
         chk($sformatf("vec%0d_cnt_round_up", i), {16'd0, bus.o_cnt_round_up}, ru_exp);
         chk($sformatf("vec%0d_cnt_overflow", i), {16'd0, bus.o_cnt_overflow}, ov_exp);
         chk($sformatf("vec%0d_cnt_flush", i), {16'd0, bus.o_cnt_flush}, fl_exp);
      end

      // Backpressure: 6 words back-to-back, i_ready low on cycles 3..5
      sent = 0; rcvd = 0;
      for (int c = 0; c < 6; c++) out_cyc[c] = -1;
      for (int cyc = 0; cyc < 30 && rcvd < 6; cyc++) begin
         @(negedge clk);
         bus.i_ready = !(cyc >= 3 && cyc <= 5);
         bus.i_valid = (sent < 6);
         if (sent < 6) bus.i_data = bp_in[sent];
         #1;
         if (cyc >= 3 && cyc <= 5) begin
            chk($sformatf("bp_stall%0d_o_ready", cyc), {31'd0, bus.o_ready}, 32'd0);
            chk($sformatf("bp_stall%0d_o_valid", cyc), {31'd0, bus.o_valid}, 32'd1);
            chk($sformatf("bp_stall%0d_hold_data", cyc), bus.o_data, bp_exp[1]);
         end
         if (bus.o_valid && bus.i_ready) begin
            chk($sformatf("bp_out%0d", rcvd), bus.o_data, bp_exp[rcvd]);
            out_cyc[rcvd] = cyc;
            rcvd++;
         end
         if (bus.i_valid && bus.o_ready) sent++;
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      chk("bp_words_received", rcvd, 32'd6);
      chk("bp_first_after_stall", out_cyc[1], 32'd6);
      for (int k = 2; k < 6; k++) begin
         chk($sformatf("bp_back_to_back%0d", k), out_cyc[k], out_cyc[k-1] + 1);
      end

      // Reset with two words in flight
      @(negedge clk);
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h3F818000;
      @(negedge clk);
      bus.i_data  = 32'h40490FDB;
      @(negedge clk);
      bus.i_valid = 1'b0;
      #1;
      chk("rst_mid_in_flight_o_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("rst_mid_in_flight_o_ready", {31'd0, bus.o_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_o_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("rst_mid_o_data", bus.o_data, 32'd0);
      chk("rst_mid_cnt_round_up", {16'd0, bus.o_cnt_round_up}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      seen_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         if (bus.o_valid) seen_cnt++;
      end
      chk("rst_mid_no_stale_word", seen_cnt, 32'd0);
      chk("rst_mid_o_ready", {31'd0, bus.o_ready}, 32'd1);

      // Clear wins over a same-cycle rounding event
      @(negedge clk);
      bus.i_data    = 32'h3F818000;
      bus.i_valid   = 1'b1;
      bus.i_clr_cnt = 1'b1;
      @(negedge clk);
      bus.i_valid   = 1'b0;
      bus.i_clr_cnt = 1'b0;
      #1;
      chk("clr_cnt_round_up", {16'd0, bus.o_cnt_round_up}, 32'd0);
      repeat (3) @(negedge clk);
      send_one(32'h3F818000, got, seen);
      chk("clr_after_data", got, 32'h3F820000);
      chk("clr_after_cnt_round_up", {16'd0, bus.o_cnt_round_up}, 32'd1);

      // Saturation on the 2-bit counter instance
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         #1;
         if (k > 0) begin
            chk($sformatf("sat_cnt_after%0d", k), {30'd0, bus2.o_cnt_round_up}, (k > 3) ? 32'd3 : k);
         end
         bus2.i_ready = 1'b1;
         bus2.i_valid = (k < 5);
         bus2.i_data  = 32'h3F818000;
      end
      bus2.i_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
